// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the state type of the single-beat master.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW_W,
      ST_B
   } master_state_t;

endpackage

// File: rtl/axi_single_beat_master.sv
// Core request port to AXI4 master bridge: one single-beat INCR read or write
// in flight at a time, with a registered one-cycle completion pulse.
module axi_single_beat_master
   import axi_pkg::*;
#(
   parameter int          ID_W      = 4,
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int unsigned MASTER_ID = 0
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                done_o,
   output logic                err_o,
   output logic                busy_o,
   output logic [ID_W-1:0]     AWID_M,
   output logic [ADDR_W-1:0]   AWADDR_M,
   output logic [3:0]          AWLEN_M,
   output logic [2:0]          AWSIZE_M,
   output logic [1:0]          AWBURST_M,
   output logic                AWVALID_M,
   input  logic                AWREADY_M,
   output logic [DATA_W-1:0]   WDATA_M,
   output logic [DATA_W/8-1:0] WSTRB_M,
   output logic                WLAST_M,
   output logic                WVALID_M,
   input  logic                WREADY_M,
   input  logic [ID_W-1:0]     BID_M,
   input  logic [1:0]          BRESP_M,
   input  logic                BVALID_M,
   output logic                BREADY_M,
   output logic [ID_W-1:0]     ARID_M,
   output logic [ADDR_W-1:0]   ARADDR_M,
   output logic [3:0]          ARLEN_M,
   output logic [2:0]          ARSIZE_M,
   output logic [1:0]          ARBURST_M,
   output logic                ARVALID_M,
   input  logic                ARREADY_M,
   input  logic [ID_W-1:0]     RID_M,
   input  logic [DATA_W-1:0]   RDATA_M,
   input  logic [1:0]          RRESP_M,
   input  logic                RLAST_M,
   input  logic                RVALID_M,
   output logic                RREADY_M
);

   localparam logic [ID_W-1:0] MID = ID_W'(MASTER_ID);

   master_state_t       state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_done;
   logic                w_done;
   logic                r_bad;
   logic                b_bad;

   assign AWID_M    = MID;
   assign AWADDR_M  = addr_q;
   assign AWLEN_M   = 4'd0;
   assign AWSIZE_M  = SIZE_4B;
   assign AWBURST_M = BURST_INCR;
   assign WDATA_M   = wdata_q;
   assign WSTRB_M   = wstrb_q;
   assign WLAST_M   = 1'b1;
   assign ARID_M    = MID;
   assign ARADDR_M  = addr_q;
   assign ARLEN_M   = 4'd0;
   assign ARSIZE_M  = SIZE_4B;
   assign ARBURST_M = BURST_INCR;
   assign busy_o    = (state != ST_IDLE);

   // A channel counts as done once its valid has dropped or it handshakes now.
   always_comb begin
      aw_done = !AWVALID_M || AWREADY_M;
      w_done  = !WVALID_M || WREADY_M;
      r_bad   = (RRESP_M != RESP_OKAY) || (RID_M != MID) || !RLAST_M;
      b_bad   = (BRESP_M != RESP_OKAY) || (BID_M != MID);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_o   <= '0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         AWVALID_M <= 1'b0;
         WVALID_M  <= 1'b0;
         BREADY_M  <= 1'b0;
         ARVALID_M <= 1'b0;
         RREADY_M  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_i) begin
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  wstrb_q <= wstrb_i;
                  if (we_i) begin
                     AWVALID_M <= 1'b1;
                     WVALID_M  <= 1'b1;
                     state     <= ST_AW_W;
                  end else begin
                     ARVALID_M <= 1'b1;
                     state     <= ST_AR;
                  end
               end
            end
            ST_AR: begin
               if (ARREADY_M) begin
                  ARVALID_M <= 1'b0;
                  RREADY_M  <= 1'b1;
                  state     <= ST_R;
               end
            end
            ST_R: begin
               // Erroneous responses are consumed and their data kept all the same.
               if (RVALID_M) begin
                  RREADY_M <= 1'b0;
                  rdata_o  <= RDATA_M;
                  done_o   <= 1'b1;
                  err_o    <= r_bad;
                  state    <= ST_IDLE;
               end
            end
            ST_AW_W: begin
               if (AWREADY_M) AWVALID_M <= 1'b0;
               if (WREADY_M)  WVALID_M  <= 1'b0;
               if (aw_done && w_done) begin
                  BREADY_M <= 1'b1;
                  state    <= ST_B;
               end
            end
            ST_B: begin
               if (BVALID_M) begin
                  BREADY_M <= 1'b0;
                  done_o   <= 1'b1;
                  err_o    <= b_bad;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Directed bench for axi_single_beat_master: a reactive slave with per-transaction
// ready/response delays and a timeline model of when each output must be active.
module tb_axi_single_beat_master;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              ACLK;
   logic              ARESET;
   logic              req_i;
   logic              we_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic [3:0]        wstrb_i;
   logic [DATA_W-1:0] rdata_o;
   logic              done_o;
   logic              err_o;
   logic              busy_o;
   logic [ID_W-1:0]   AWID_M;
   logic [ADDR_W-1:0] AWADDR_M;
   logic [3:0]        AWLEN_M;
   logic [2:0]        AWSIZE_M;
   logic [1:0]        AWBURST_M;
   logic              AWVALID_M;
   logic              AWREADY_M;
   logic [DATA_W-1:0] WDATA_M;
   logic [3:0]        WSTRB_M;
   logic              WLAST_M;
   logic              WVALID_M;
   logic              WREADY_M;
   logic [ID_W-1:0]   BID_M;
   logic [1:0]        BRESP_M;
   logic              BVALID_M;
   logic              BREADY_M;
   logic [ID_W-1:0]   ARID_M;
   logic [ADDR_W-1:0] ARADDR_M;
   logic [3:0]        ARLEN_M;
   logic [2:0]        ARSIZE_M;
   logic [1:0]        ARBURST_M;
   logic              ARVALID_M;
   logic              ARREADY_M;
   logic [ID_W-1:0]   RID_M;
   logic [DATA_W-1:0] RDATA_M;
   logic [1:0]        RRESP_M;
   logic              RLAST_M;
   logic              RVALID_M;
   logic              RREADY_M;

   axi_single_beat_master #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_ID(0)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
      .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M),
      .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
      .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
      .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
      .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
      .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic cmp_en = 1'b0;

   // Current transaction as the model sees it; the slave answers from the same record.
   logic        m_active = 1'b0;
   int          m_t0 = 0;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   int          m_da = 0;
   int          m_dw = 0;
   int          m_dr = 0;
   logic [1:0]  m_resp = '0;
   logic [3:0]  m_id = '0;
   logic        m_last = 1'b1;
   logic [31:0] m_rdata = '0;
   logic [31:0] exp_rdata = '0;

   int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
   logic seen_err, seen_busy;

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Outputs follow fixed windows measured from the acceptance cycle and the slave delays.
   task automatic compare_cycle();
      logic e_ar, e_r, e_aw, e_w, e_b, e_done, e_busy, e_err;
      int   rel, m;
      e_ar = 0; e_r = 0; e_aw = 0; e_w = 0; e_b = 0; e_done = 0; e_busy = 0; e_err = 0;
      if (m_active) begin
         rel = cyc - m_t0;
         if (!m_we) begin
            e_ar   = (rel >= 1) && (rel <= 1 + m_da);
            e_r    = (rel >= 2 + m_da) && (rel <= 2 + m_da + m_dr);
            e_done = (rel == 3 + m_da + m_dr);
            e_busy = (rel >= 1) && (rel <= 2 + m_da + m_dr);
            e_err  = e_done && ((m_resp != 2'b00) || (m_id != 4'd0) || !m_last);
            if (e_done) exp_rdata = m_rdata;
         end else begin
            m      = (m_da > m_dw) ? m_da : m_dw;
            e_aw   = (rel >= 1) && (rel <= 1 + m_da);
            e_w    = (rel >= 1) && (rel <= 1 + m_dw);
            e_b    = (rel >= 2 + m) && (rel <= 2 + m + m_dr);
            e_done = (rel == 3 + m + m_dr);
            e_busy = (rel >= 1) && (rel <= 2 + m + m_dr);
            e_err  = e_done && ((m_resp != 2'b00) || (m_id != 4'd0));
         end
      end
      check_output("arvalid", ARVALID_M, e_ar);
      check_output("rready", RREADY_M, e_r);
      check_output("awvalid", AWVALID_M, e_aw);
      check_output("wvalid", WVALID_M, e_w);
      check_output("bready", BREADY_M, e_b);
      check_output("done", done_o, e_done);
      check_output("err", err_o, e_err);
      check_output("busy", busy_o, e_busy);
      check_output("rdata", rdata_o, exp_rdata);
      if (e_ar) begin
         check_output("araddr", ARADDR_M, m_addr);
         check_output("ar_fields", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}, {4'd0, 4'd0, 3'b010, 2'b01});
      end
      if (e_aw) begin
         check_output("awaddr", AWADDR_M, m_addr);
         check_output("aw_fields", {AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}, {4'd0, 4'd0, 3'b010, 2'b01});
      end
      if (e_w) begin
         check_output("wdata", WDATA_M, m_wdata);
         check_output("wstrb_wlast", {WSTRB_M, WLAST_M}, {m_wstrb, 1'b1});
      end
   endtask

   always @(posedge ACLK) begin
      #1;
      if (cmp_en) compare_cycle();
   end

   // Reactive slave: each ready/valid rises after its master-side signal has been up m_d* cycles.
   always @(negedge ACLK) begin
      ARREADY_M = ARVALID_M && (ar_cnt == m_da);
      ar_cnt    = ARVALID_M ? ar_cnt + 1 : 0;
      AWREADY_M = AWVALID_M && (aw_cnt == m_da);
      aw_cnt    = AWVALID_M ? aw_cnt + 1 : 0;
      WREADY_M  = WVALID_M && (w_cnt == m_dw);
      w_cnt     = WVALID_M ? w_cnt + 1 : 0;
      RVALID_M  = RREADY_M && (r_cnt == m_dr);
      r_cnt     = RREADY_M ? r_cnt + 1 : 0;
      RDATA_M   = RVALID_M ? m_rdata : 32'h0;
      RRESP_M   = m_resp;
      RID_M     = m_id;
      RLAST_M   = m_last;
      BVALID_M  = BREADY_M && (b_cnt == m_dr);
      b_cnt     = BREADY_M ? b_cnt + 1 : 0;
      BRESP_M   = m_resp;
      BID_M     = m_id;
   end

   task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int da, input int dw, input int dr,
                                 input logic [1:0] resp, input logic [3:0] id, input logic last,
                                 input logic [31:0] rdata);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = addr;
      wdata_i = wdata;
      wstrb_i = wstrb;
      m_we = we; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
      m_da = da; m_dw = dw; m_dr = dr;
      m_resp = resp; m_id = id; m_last = last; m_rdata = rdata;
      m_t0 = cyc;
      m_active = 1'b1;
   endtask

   task automatic wait_done(input int limit, input logic scramble, output int done_rel);
      done_rel = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge ACLK);
         if (done_o === 1'b1) begin
            done_rel  = cyc - m_t0;
            seen_err  = err_o;
            seen_busy = busy_o;
            break;
         end
         if (scramble) begin
            req_i   = 1'($urandom_range(0, 1));
            we_i    = 1'($urandom_range(0, 1));
            addr_i  = $urandom;
            wdata_i = $urandom;
         end
      end
      if (done_rel < 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL done_timeout: got no done_o within %0d cycles, expected a pulse", limit);
      end
   endtask

   initial begin
      int rel;
      int t_end;
      ARESET = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
      ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0; RVALID_M = 0; BVALID_M = 0;
      RDATA_M = '0; RRESP_M = '0; RID_M = '0; RLAST_M = 0; BRESP_M = '0; BID_M = '0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESET = 1'b0;
      cmp_en = 1'b1;
      check_output("reset_busy", busy_o, 1'b0);
      check_output("reset_rdata", rdata_o, 32'h0);
      check_output("reset_valids", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, done_o, err_o}, 7'b0);

      $display("[TB] zero-wait read");
      @(negedge ACLK);
      apply_stimulus(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 4'd0, 1'b1, 32'hDEAD_BEEF);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("rd_latency", rel, 3);
      check_output("rd_data", rdata_o, 32'hDEAD_BEEF);
      check_output("rd_err", seen_err, 1'b0);

      $display("[TB] write, W before AW");
      @(negedge ACLK);
      apply_stimulus(1'b1, 32'h0000_2008, 32'h1234_5678, 4'b0011, 2, 0, 0, 2'b00, 4'd0, 1'b1, 32'h0);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("wr_latency", rel, 5);
      check_output("wr_err", seen_err, 1'b0);

      $display("[TB] unmapped read, DECERR");
      @(negedge ACLK);
      apply_stimulus(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 0, 0, 0, 2'b11, 4'd0, 1'b1, 32'h0BAD_0BAD);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("decerr_latency", rel, 3);
      check_output("decerr_err", seen_err, 1'b1);
      check_output("decerr_busy", seen_busy, 1'b0);
      check_output("decerr_rdata", rdata_o, 32'h0BAD_0BAD);

      $display("[TB] read with AR backpressure and noisy request inputs");
      @(negedge ACLK);
      apply_stimulus(1'b0, 32'h0000_3000, 32'h0, 4'h0, 5, 0, 1, 2'b00, 4'd0, 1'b1, 32'hA5A5_5A5A);
      wait_done(40, 1'b1, rel);
      req_i = 1'b0;
      check_output("bp_latency", rel, 9);
      check_output("bp_rdata", rdata_o, 32'hA5A5_5A5A);

      $display("[TB] error variants");
      @(negedge ACLK);
      apply_stimulus(1'b1, 32'h0000_3010, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 2'b00, 4'd5, 1'b1, 32'h0);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("bid_err", seen_err, 1'b1);
      @(negedge ACLK);
      apply_stimulus(1'b0, 32'h0000_3020, 32'h0, 4'h0, 0, 0, 2, 2'b00, 4'd0, 1'b0, 32'h1111_2222);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("rlast_err", seen_err, 1'b1);
      check_output("rlast_rdata", rdata_o, 32'h1111_2222);
      @(negedge ACLK);
      apply_stimulus(1'b1, 32'h0000_3030, 32'h0F0F_0F0F, 4'b1000, 1, 3, 0, 2'b10, 4'd0, 1'b1, 32'h0);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("slverr_latency", rel, 6);
      check_output("slverr_err", seen_err, 1'b1);

      $display("[TB] reset during B wait");
      @(negedge ACLK);
      apply_stimulus(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'b0101, 0, 0, 10, 2'b00, 4'd0, 1'b1, 32'h0);
      repeat (4) @(negedge ACLK);
      ARESET = 1'b1;
      req_i = 1'b0;
      m_active = 1'b0;
      exp_rdata = 32'h0;
      @(negedge ACLK);
      ARESET = 1'b0;
      check_output("rst_bready", BREADY_M, 1'b0);
      check_output("rst_busy", busy_o, 1'b0);
      check_output("rst_done", done_o, 1'b0);
      @(negedge ACLK);
      apply_stimulus(1'b0, 32'h0000_4004, 32'h0, 4'h0, 1, 0, 0, 2'b00, 4'd0, 1'b1, 32'h7777_8888);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("post_rst_latency", rel, 4);
      check_output("post_rst_rdata", rdata_o, 32'h7777_8888);
      check_output("post_rst_err", seen_err, 1'b0);

      $display("[TB] back-to-back write then read");
      @(negedge ACLK);
      apply_stimulus(1'b1, 32'h0000_5000, 32'h0BEE_F00D, 4'b1100, 0, 1, 0, 2'b00, 4'd0, 1'b1, 32'h0);
      wait_done(30, 1'b0, rel);
      check_output("b2b_wr_latency", rel, 4);
      t_end = cyc;
      apply_stimulus(1'b0, 32'h0000_6000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 4'd0, 1'b1, 32'h600D_600D);
      @(posedge ACLK);
      #1;
      check_output("b2b_arvalid_cycle", cyc - t_end, 1);
      check_output("b2b_arvalid", ARVALID_M, 1'b1);
      check_output("b2b_araddr", ARADDR_M, 32'h0000_6000);
      wait_done(30, 1'b0, rel);
      req_i = 1'b0;
      check_output("b2b_rd_latency", rel, 3);
      check_output("b2b_rdata", rdata_o, 32'h600D_600D);

      repeat (3) @(negedge ACLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
